// File: rtl/alu_share_sequencer.sv
// Shares one 32-bit ALU between two requesters with round-robin arbitration.
// Results are registered and held until accepted; shift-left takes one bit per cycle.
module alu_share_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_ovf,
    output logic             res_carry,
    output logic             res_err,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic               ptr;
    logic [2:0]         op_q;
    logic               id_q;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   b_q;
    logic [SHAMT_W-1:0] cnt;
    logic               sh_carry;

    logic               idle;
    logic               gnt0;
    logic               gnt1;
    logic               take;
    logic               shift_step;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     dif_w;
    logic [WIDTH-1:0]   nx_data;
    logic               nx_ovf;
    logic               nx_carry;
    logic               nx_err;

    // Ties go to the port named by ptr; a lone valid always wins.
    assign idle       = (state == S_IDLE);
    assign gnt0       = req0_valid & (~req1_valid | ~ptr);
    assign gnt1       = req1_valid & (~req0_valid | ptr);
    assign req0_ready = idle & gnt0;
    assign req1_ready = idle & gnt1;
    assign take       = req0_ready | req1_ready;
    assign res_valid  = (state == S_HOLD);
    assign busy       = ~idle;
    assign shift_step = (op_q == OP_SHL) && (cnt != '0);

    always_comb begin
        sum_w    = {1'b0, acc} + {1'b0, b_q};
        dif_w    = {1'b0, acc} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        nx_data  = '0;
        nx_ovf   = 1'b0;
        nx_carry = 1'b0;
        nx_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                nx_data  = sum_w[WIDTH-1:0];
                nx_carry = sum_w[WIDTH];
                nx_ovf   = (acc[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                nx_data  = dif_w[WIDTH-1:0];
                nx_carry = dif_w[WIDTH];
                nx_ovf   = (acc[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND: nx_data = acc & b_q;
            OP_OR:  nx_data = acc | b_q;
            OP_XOR: nx_data = acc ^ b_q;
            OP_SLT: nx_data = {{(WIDTH-1){1'b0}}, (acc < b_q)};
            OP_SHL: begin
                nx_data  = acc;
                nx_carry = sh_carry;
            end
            default: nx_err = 1'b1;
        endcase
    end

    // acc doubles as operand A and as the shift register for shl.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= 1'b0;
            op_q      <= '0;
            id_q      <= 1'b0;
            acc       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            sh_carry  <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
            res_ovf   <= 1'b0;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        op_q     <= req1_ready ? req1_op : req0_op;
                        acc      <= req1_ready ? req1_a : req0_a;
                        b_q      <= req1_ready ? req1_b : req0_b;
                        cnt      <= req1_ready ? req1_b[SHAMT_W-1:0] : req0_b[SHAMT_W-1:0];
                        id_q     <= req1_ready;
                        sh_carry <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (shift_step) begin
                        acc      <= acc << 1;
                        sh_carry <= acc[WIDTH-1];
                        cnt      <= cnt - CNT_ONE;
                    end else begin
                        res_id    <= id_q;
                        res_data  <= nx_data;
                        res_zero  <= (nx_data == '0);
                        res_neg   <= nx_data[WIDTH-1];
                        res_ovf   <= nx_ovf;
                        res_carry <= nx_carry;
                        res_err   <= nx_err;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        ptr   <= ~res_id;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Randomised scoreboard bench for alu_share_sequencer: a reference model predicts
// arbitration, result timing and values; a negedge monitor checks the DUT against it.
module tb_alu_share_sequencer;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [4:0]  flags;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        vld0, vld1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        req0_ready, req1_ready;
    logic        res_valid, res_ready, res_id;
    logic [31:0] res_data;
    logic        res_zero, res_neg, res_ovf, res_carry, res_err, busy;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rr_mode = 0;
    logic ptr_m = 1'b0;
    logic took0 = 1'b0;
    logic took1 = 1'b0;
    logic prev_hold = 1'b0;
    logic [38:0] snap;

    alu_share_sequencer #(.WIDTH(32), .SHAMT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (vld0),
        .req0_ready (req0_ready),
        .req0_op    (op0),
        .req0_a     (a0),
        .req0_b     (b0),
        .req1_valid (vld1),
        .req1_ready (req1_ready),
        .req1_op    (op1),
        .req1_a     (a1),
        .req1_b     (b1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_neg    (res_neg),
        .res_ovf    (res_ovf),
        .res_carry  (res_carry),
        .res_err    (res_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op;
        r.a  = a;
        r.b  = b;
        if (port == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    // Reference: results from plain arithmetic, timing from the op's cycle count.
    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b, input int now);
        exp_t        e;
        logic [63:0] r;
        logic        ovf, carry, err;
        int          n;
        ovf = 1'b0; carry = 1'b0; err = 1'b0; n = 0;
        r = 64'd0;
        case (op)
            3'd0: begin
                r = {32'd0, a} + {32'd0, b};
                carry = r[32];
                ovf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r[31:0] = a - b;
                carry = (a >= b);
                ovf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r[31:0] = a & b;
            3'd3: r[31:0] = a | b;
            3'd4: r[31:0] = a ^ b;
            3'd5: r[31:0] = (a < b) ? 32'd1 : 32'd0;
            3'd6: begin
                n = int'(b[1:0]);
                r = {32'd0, a} << n;
                carry = r[32];
            end
            default: err = 1'b1;
        endcase
        e.id    = id;
        e.data  = r[31:0];
        e.flags = {(r[31:0] == 32'd0), r[31], ovf, carry, err};
        e.due   = now + 2 + n;
        return e;
    endfunction

    task automatic checkResetState();
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_flags", {res_zero, res_neg, res_ovf, res_carry, res_err}, 0);
        checkOutput("rst_ready", {req0_ready, req1_ready}, 0);
    endtask

    task automatic waitDrain(input int maxc);
        int c = 0;
        @(negedge clk);
        while (!(q0.size() == 0 && q1.size() == 0 && !vld0 && !vld1 && sb.size() == 0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d results still pending after %0d cycles, expected 0", sb.size(), maxc);
        end
    endtask

    // Requester 0: holds valid and operands stable until the accept edge.
    initial begin
        req_t r;
        vld0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                vld0 = 1'b0;
                q0.delete();
            end else if (!vld0 || took0) begin
                if (q0.size() > 0) begin
                    r = q0.pop_front();
                    op0 = r.op; a0 = r.a; b0 = r.b; vld0 = 1'b1;
                end else vld0 = 1'b0;
            end
        end
    end

    initial begin
        req_t r;
        vld1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                vld1 = 1'b0;
                q1.delete();
            end else if (!vld1 || took1) begin
                if (q1.size() > 0) begin
                    r = q1.pop_front();
                    op1 = r.op; a1 = r.a; b1 = r.b; vld1 = 1'b1;
                end else vld1 = 1'b0;
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: values seen at a negedge are those the next rising edge samples.
    always @(negedge clk) begin
        logic bsy, g0, g1, erv;
        exp_t e;
        if (reset) begin
            sb.delete();
            ptr_m = 1'b0;
            took0 = 1'b0;
            took1 = 1'b0;
            prev_hold = 1'b0;
        end else begin
            bsy = (sb.size() > 0);
            g0  = !bsy && vld0 && (!vld1 || ptr_m == 1'b0);
            g1  = !bsy && vld1 && (!vld0 || ptr_m == 1'b1);
            erv = bsy ? (cyc >= sb[0].due) : 1'b0;
            checkOutput("req0_ready", req0_ready, g0);
            checkOutput("req1_ready", req1_ready, g1);
            checkOutput("busy", busy, bsy);
            checkOutput("res_valid", res_valid, erv);
            if (prev_hold)
                checkOutput("hold_stable", {res_id, res_data, res_zero, res_neg, res_ovf, res_carry, res_err}, snap);
            if (res_valid && res_ready && bsy) begin
                e = sb.pop_front();
                checkOutput("res_id", res_id, e.id);
                checkOutput("res_data", res_data, e.data);
                checkOutput("res_flags(z,n,v,c,e)", {res_zero, res_neg, res_ovf, res_carry, res_err}, e.flags);
                ptr_m = ~e.id;
            end
            if (vld0 && req0_ready) sb.push_back(model(1'b0, op0, a0, b0, cyc));
            if (vld1 && req1_ready) sb.push_back(model(1'b1, op1, a1, b1, cyc));
            took0 = vld0 && req0_ready;
            took1 = vld1 && req1_ready;
            prev_hold = res_valid && !res_ready;
            snap = {res_id, res_data, res_zero, res_neg, res_ovf, res_carry, res_err};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetState();

        $display("[TB] add overflow on requester 0");
        rr_mode = 0;
        applyStimulus(0, 3'd0, 32'h7FFF_FFFF, 32'h1);
        waitDrain(50);

        $display("[TB] sub with held-off consumer on requester 1");
        rr_mode = 1;
        applyStimulus(1, 3'd1, 32'd5, 32'd5);
        c = 0;
        while (!res_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput("sub_result_seen", res_valid, 1);
        repeat (3) @(negedge clk);
        rr_mode = 0;
        waitDrain(50);

        $display("[TB] both requesters valid every cycle");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3'd2 + 3'(i), $urandom, $urandom);
            applyStimulus(1, 3'd0 + 3'(i), $urandom, $urandom);
        end
        waitDrain(100);

        $display("[TB] shift-left by 3 and by 0");
        applyStimulus(0, 3'd6, 32'hA000_0001, 32'd3);
        applyStimulus(0, 3'd6, 32'hC000_0003, 32'd0);
        applyStimulus(1, 3'd6, 32'h4000_0000, 32'd1);
        waitDrain(100);

        $display("[TB] illegal opcode and slt");
        applyStimulus(1, 3'd7, $urandom, $urandom);
        applyStimulus(0, 3'd5, 32'd1, 32'hFFFF_FFFF);
        applyStimulus(0, 3'd5, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(1, 3'd1, 32'd0, 32'd1);
        applyStimulus(1, 3'd0, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(0, 3'd1, 32'h8000_0000, 32'd1);
        waitDrain(100);

        $display("[TB] reset during shift execution");
        applyStimulus(0, 3'd6, $urandom, 32'd3);
        c = 0;
        while (sb.size() == 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput("shl_accepted", (sb.size() > 0), 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetState();
        applyStimulus(1, 3'd0, $urandom, $urandom);
        waitDrain(50);
        applyStimulus(0, 3'd3, $urandom, $urandom);
        applyStimulus(1, 3'd4, $urandom, $urandom);
        waitDrain(50);

        $display("[TB] randomised traffic");
        rr_mode = 2;
        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 1)) : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            applyStimulus(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        waitDrain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
